conv3_seq_ctrl: RTL and testbench

Sequencer for the 3-tap address-counter datapath: the write address counter, the three offset read address counters and the 16-entry sample register file they address. Fills the register file with a DEPTH-sample frame, then drives a contiguous read burst of DEPTH-TAPS+1 windows. Flags datapath outputs valid after the read latency, and reports busy/done to the host.

---
 rtl/conv3_seq_ctrl_pkg.sv | 25 ++
 rtl/conv3_seq_ctrl_valid_delay_line.sv | 50 +++++
 rtl/conv3_seq_ctrl.sv | 149 ++++++++++++++
 tb/tb_conv3_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv3_seq_ctrl_pkg.sv
// Shared definitions for the 3-tap convolution sequencer.
//
// Contents:
//   seqState_t - controller state encoding (IDLE, LOAD, RUN, DRAIN, DONE)
//   calcNwin   - number of read windows in one frame (DEPTH-TAPS+1)
package conv3_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seqState_t;

    // A window of TAPS samples can start at DEPTH-TAPS+1 positions.
    function automatic int calcNwin(input int depth, input int taps);
        return depth - taps + 1;
    endfunction

    localparam int DEPTH_DEFAULT = 16;
    localparam int TAPS_DEFAULT  = 3;
    localparam int NWIN_DEFAULT  = calcNwin(DEPTH_DEFAULT, TAPS_DEFAULT);

endpackage

// File: rtl/conv3_seq_ctrl_valid_delay_line.sv
// RD_LAT-stage shift register that delays the read strobe so that it lines
// up with the datapath result.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clear      - synchronous clear of every stage (abort)
//   validIn    - strobe entering the line
//   validOut   - strobe delayed by RD_LAT cycles
//   pending    - a strobe is still travelling through the non-final stages,
//                i.e. validOut will still pulse after this cycle
module conv3_seq_ctrl_valid_delay_line #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic validIn,
    output logic validOut,
    output logic pending
);

    logic [RD_LAT-1:0] stage;

    // NOTE: every stage is reset, not just the output, so a strobe caught in
    // flight by reset can never surface as a stale out_valid afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else if (clear) begin
            stage <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the old
            // value of its neighbour, which is what makes this a shift.
            stage[0] <= validIn;
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign validOut = stage[RD_LAT-1];

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            pending = pending | stage[i];
        end
    end

endmodule

// File: rtl/conv3_seq_ctrl.sv
// Sequencer for the 3-tap address-counter datapath. Fills the sample
// register file with one DEPTH-sample frame, then issues a contiguous burst
// of NWIN read strobes, flags the datapath result valid RD_LAT cycles later
// and reports busy/done to the host.
//
// The address counters themselves live in the datapath and are never reset
// here: a complete frame advances the write counter by DEPTH and the read
// counters by NWIN. After an abort their alignment is lost until rst_n.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start_req   - host pulse, starts a frame (honoured only in IDLE)
//   abort       - synchronous abort back to IDLE from any state
//   data_valid  - input sample present this cycle
//   in_ready    - controller accepts samples (LOAD)
//   Start       - write-address advance strobe
//   WriteEn     - register-file write enable
//   ReadEn      - read-address advance strobe to all read counters
//   out_valid   - datapath result valid this cycle
//   busy        - any state other than IDLE
//   done        - one-cycle pulse at frame completion
module conv3_seq_ctrl
    import conv3_seq_ctrl_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int TAPS   = 3,
    parameter int RD_LAT = 2,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_req,
    input  logic abort,
    input  logic data_valid,
    output logic in_ready,
    output logic Start,
    output logic WriteEn,
    output logic ReadEn,
    output logic out_valid,
    output logic busy,
    output logic done
);

    localparam int NWIN = calcNwin(DEPTH, TAPS);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_WIN    = CNT_W'(NWIN - 1);

    seqState_t        state;
    seqState_t        nextState;
    logic [CNT_W-1:0] loadCnt;
    logic [CNT_W-1:0] winCnt;
    logic             pipePending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every output and nextState get a default before the case, so no
    // path through this block leaves a variable unassigned (no latches).
    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        Start     = 1'b0;
        WriteEn   = 1'b0;
        ReadEn    = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (start_req) nextState = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                Start    = data_valid;
                WriteEn  = data_valid;
                if (data_valid && loadCnt == LAST_SAMPLE) nextState = RUN;
            end
            RUN: begin
                ReadEn = 1'b1;
                if (winCnt == LAST_WIN) nextState = DRAIN;
            end
            DRAIN: begin
                // Leave once the last strobe sits in the output stage; its
                // out_valid pulse coincides with this final DRAIN cycle.
                if (!pipePending) nextState = DONE;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase

        // Abort overrides every transition and suppresses all strobes so the
        // datapath counters do not move in the abort cycle.
        if (abort) begin
            nextState = IDLE;
            Start     = 1'b0;
            WriteEn   = 1'b0;
            ReadEn    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loadCnt <= '0;
            winCnt  <= '0;
        end else if (abort) begin
            loadCnt <= '0;
            winCnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) begin
                        loadCnt <= '0;
                        winCnt  <= '0;
                    end
                end
                LOAD: begin
                    if (data_valid) loadCnt <= loadCnt + 1'b1;
                end
                RUN: begin
                    winCnt <= winCnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    conv3_seq_ctrl_valid_delay_line #(
        .RD_LAT (RD_LAT)
    ) u_validPipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (abort),
        .validIn  (ReadEn),
        .validOut (out_valid),
        .pending  (pipePending)
    );

endmodule

// File: tb/tb_conv3_seq_ctrl.sv
// Scoreboard bench for conv3_seq_ctrl: the driver pushes the cycle numbers at
// which each strobe must appear; the monitor pops them as the DUT pulses.
module tb_conv3_seq_ctrl;

    localparam int DEPTH  = 16;
    localparam int TAPS   = 3;
    localparam int RD_LAT = 2;
    localparam int NWIN   = DEPTH - TAPS + 1;

    logic clk = 1'b0;
    logic rst_n;
    logic start_req;
    logic abort;
    logic data_valid;
    logic in_ready;
    logic Start;
    logic WriteEn;
    logic ReadEn;
    logic out_valid;
    logic busy;
    logic done;

    int cyc     = 0;
    int nChecks = 0;
    int nFail   = 0;
    bit monEn      = 1'b0;
    bit expBusy    = 1'b0;
    bit expInReady = 1'b0;

    int startQ[$];
    int writeQ[$];
    int readQ[$];
    int validQ[$];
    int doneQ[$];

    conv3_seq_ctrl #(
        .DEPTH  (DEPTH),
        .TAPS   (TAPS),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_req  (start_req),
        .abort      (abort),
        .data_valid (data_valid),
        .in_ready   (in_ready),
        .Start      (Start),
        .WriteEn    (WriteEn),
        .ReadEn     (ReadEn),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Monitor: level checks every cycle, strobe cycles against the scoreboard.
    always @(negedge clk) begin
        if (monEn) begin
            check("busy", busy, expBusy);
            check("in_ready", in_ready, expInReady);
            if (Start) begin
                if (startQ.size() == 0) check("Start_spurious", Start, 0);
                else                    check("Start_cycle", cyc, startQ.pop_front());
            end
            if (WriteEn) begin
                if (writeQ.size() == 0) check("WriteEn_spurious", WriteEn, 0);
                else                    check("WriteEn_cycle", cyc, writeQ.pop_front());
            end
            if (ReadEn) begin
                if (readQ.size() == 0) check("ReadEn_spurious", ReadEn, 0);
                else                   check("ReadEn_cycle", cyc, readQ.pop_front());
            end
            if (out_valid) begin
                if (validQ.size() == 0) check("out_valid_spurious", out_valid, 0);
                else                    check("out_valid_cycle", cyc, validQ.pop_front());
            end
            if (done) begin
                if (doneQ.size() == 0) check("done_spurious", done, 0);
                else                   check("done_cycle", cyc, doneQ.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkDrained(input string tag);
        check({tag, "_startQ_left"}, startQ.size(), 0);
        check({tag, "_writeQ_left"}, writeQ.size(), 0);
        check({tag, "_readQ_left"},  readQ.size(),  0);
        check({tag, "_validQ_left"}, validQ.size(), 0);
        check({tag, "_doneQ_left"},  doneQ.size(),  0);
    endtask

    // One frame from IDLE. gapped: data_valid alternates 1/0. pokeStart:
    // start_req also pulsed in LOAD, RUN and the DONE cycle. abortAfter >= 0:
    // abort after that many ReadEn cycles. resetAt >= 0: async reset while
    // the sample with that index is being presented.
    task automatic runFrame(input bit gapped, input bit pokeStart,
                            input int abortAfter, input int resetAt);
        int accepted;
        int phase;
        int s;
        int abortCyc;
        int doneCyc;
        int busyLast;
        int endCyc;
        bit dv;
        accepted = 0;
        phase    = 0;
        s        = 0;
        abortCyc = -1;
        doneCyc  = -1;
        busyLast = 0;
        endCyc   = 0;

        start_req  = 1'b1;
        expBusy    = 1'b0;
        expInReady = 1'b0;
        tick();
        start_req  = 1'b0;
        expBusy    = 1'b1;
        expInReady = 1'b1;

        while (accepted < DEPTH) begin
            dv = gapped ? ((phase % 2) == 0) : 1'b1;
            start_req = pokeStart && (phase == 4);
            if (resetAt >= 0 && accepted == resetAt) begin
                data_valid = 1'b1;
                #1;
                rst_n      = 1'b0;
                expBusy    = 1'b0;
                expInReady = 1'b0;
                #1;
                check("async_rst_outputs",
                      {25'd0, Start, WriteEn, ReadEn, out_valid, in_ready, busy, done}, 0);
                data_valid = 1'b0;
                start_req  = 1'b0;
                repeat (2) tick();
                #2 rst_n = 1'b1;
                return;
            end
            data_valid = dv;
            if (dv) begin
                startQ.push_back(cyc);
                writeQ.push_back(cyc);
                accepted++;
                if (accepted == DEPTH) begin
                    s = cyc;
                    if (abortAfter >= 0) begin
                        abortCyc = s + 1 + abortAfter;
                        for (int r = s + 1; r < abortCyc; r++) begin
                            readQ.push_back(r);
                            if (r + RD_LAT <= abortCyc) validQ.push_back(r + RD_LAT);
                        end
                        busyLast = abortCyc;
                        endCyc   = abortCyc + 3;
                    end else begin
                        for (int r = s + 1; r <= s + NWIN; r++) begin
                            readQ.push_back(r);
                            validQ.push_back(r + RD_LAT);
                        end
                        doneCyc = s + NWIN + RD_LAT + 1;
                        doneQ.push_back(doneCyc);
                        busyLast = doneCyc;
                        endCyc   = doneCyc + 2;
                    end
                end
            end
            phase++;
            tick();
        end

        data_valid = 1'b0;
        start_req  = 1'b0;
        expInReady = 1'b0;
        while (cyc <= endCyc) begin
            abort     = (cyc == abortCyc);
            start_req = pokeStart && (cyc == s + 3 || cyc == doneCyc);
            expBusy   = (cyc <= busyLast);
            tick();
        end
        abort     = 1'b0;
        start_req = 1'b0;
        expBusy   = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        start_req  = 1'b0;
        abort      = 1'b0;
        data_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {25'd0, Start, WriteEn, ReadEn, out_valid, in_ready, busy, done}, 0);
        #1 rst_n = 1'b1;
        monEn = 1'b1;
        repeat (10) tick();
        check("idle_outputs",
              {25'd0, Start, WriteEn, ReadEn, out_valid, in_ready, busy, done}, 0);

        runFrame(1'b0, 1'b0, -1, -1);
        checkDrained("nominal");

        runFrame(1'b1, 1'b0, -1, -1);
        checkDrained("gapped");

        runFrame(1'b0, 1'b1, -1, -1);
        checkDrained("start_ignored");

        runFrame(1'b0, 1'b0, 5, -1);
        checkDrained("abort");

        runFrame(1'b0, 1'b0, -1, 7);
        checkDrained("async_reset");
        tick();

        runFrame(1'b0, 1'b0, -1, -1);
        checkDrained("after_reset");

        monEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
